mux_rr_arbiter: RTL and testbench

//  Shares one output channel among N requesters; drives the select of an internal

---
 rtl/mux_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// N-to-1 round-robin arbiter feeding a muxNto1 into one registered valid/ready output stage.
// Define MUXARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.

module muxNto1 #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [N-1:0][WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]        sel_i,
   output logic [WIDTH-1:0]        data_o
);

   always_comb begin
      data_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (sel_i == SEL_W'(i)) data_o = data_i[i];
      end
   end

endmodule

module mux_rr_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N-1:0]             in_valid,
   input  logic [N-1:0][WIDTH-1:0]  in_bus,
   output logic [N-1:0]             in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(N)-1:0]     out_sel
);

   localparam int SEL_W = $clog2(N);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   last_grant_q, last_grant_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [SEL_W-1:0]   win_idx;
   logic               win_found;
   logic               space;
   logic               accept;
   logic [WIDTH-1:0]   mux_data;

`ifdef MUXARB_FIXED_PRIO_EN
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!win_found && in_valid[i]) begin
            win_found = 1'b1;
            win_idx   = SEL_W'(i);
         end
      end
   end
`else
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);
   logic [SEL_W-1:0] scan_idx;

   // Scan starts one past the last grant; wrap is explicit so non-power-of-2 N works.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = last_grant_q;
      for (int unsigned k = 0; k < N; k++) begin
         scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
         if (!win_found && in_valid[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end
`endif

   assign space  = (state_q == EMPTY) || out_ready;
   assign accept = !rst && space && win_found;

   always_comb begin
      in_ready = '0;
      if (accept) in_ready[win_idx] = 1'b1;
   end

   muxNto1 #(
      .N     (N),
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_mux (
      .data_i (in_bus),
      .sel_i  (win_idx),
      .data_o (mux_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= EMPTY;
         last_grant_q <= SEL_W'(N - 1);
         sel_q        <= '0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         sel_q        <= sel_d;
         data_q       <= data_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      sel_d        = sel_q;
      data_d       = data_q;
      if (accept) begin
         state_d      = FULL;
         last_grant_d = win_idx;
         sel_d        = win_idx;
         data_d       = mux_data;
      end else if (state_q == FULL && out_ready) begin
         state_d = EMPTY;
      end
   end

   always_comb begin
      out_valid = (state_q == FULL);
      out_data  = data_q;
      out_sel   = sel_q;
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (N=5, WIDTH=8): directed scenarios then random traffic
// against a queue-free arithmetic reference model.

module tb_mux_rr_arbiter;

   localparam int N  = 5;
   localparam int W  = 8;
   localparam int SW = $clog2(N);

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N-1:0]          in_valid;
   logic [N-1:0][W-1:0]   in_bus;
   logic [N-1:0]          in_ready;
   logic                  out_valid;
   logic                  out_ready;
   logic [W-1:0]          out_data;
   logic [SW-1:0]         out_sel;

   int vectors     = 0;
   int miscompares = 0;

   int m_valid, m_data, m_sel, m_last;
   int last_win;

   always #5 clk = ~clk;

   mux_rr_arbiter #(.N(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_bus    (in_bus),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   function automatic int ref_winner(input logic [N-1:0] v, input int last);
`ifdef MUXARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (v[i]) return i;
`else
      for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge.
   task automatic tick();
      int           w;
      bit           acc;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      w       = ref_winner(in_valid, m_last);
      acc     = !rst && (m_valid == 0 || out_ready) && (w >= 0);
      exp_rdy = '0;
      if (acc) exp_rdy[w] = 1'b1;
      chk("in_ready",  32'(in_ready),  32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data",  32'(out_data),  32'(m_data));
      chk("out_sel",   32'(out_sel),   32'(m_sel));
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_data = 0; m_sel = 0; m_last = N - 1;
      end else if (acc) begin
         m_valid = 1; m_data = int'(in_bus[w]); m_sel = w; m_last = w;
      end else if (out_ready) begin
         m_valid = 0;
      end
      last_win = acc ? w : -1;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic int fx(input int rr_val);
`ifdef MUXARB_FIXED_PRIO_EN
      return 0;
`else
      return rr_val;
`endif
   endfunction

   initial begin
      for (int i = 0; i < N; i++) in_bus[i] = W'(10 + i);
      rst       = 1'b1;
      in_valid  = '1;
      out_ready = 1'b1;
      m_valid = 0; m_data = 0; m_sel = 0; m_last = N - 1; last_win = -1;
      @(posedge clk); #1;

      // Reset held with all requesters valid
      tick();
      tick();
      chk("t1_out_valid", 32'(out_valid), 0);
      chk("t1_out_data",  32'(out_data),  0);
      chk("t1_out_sel",   32'(out_sel),   0);
      rst = 1'b0;

      // Single requester
      in_valid = 5'b00100;
      tick();
      chk("t2_grant",     32'(last_win),  2);
      chk("t2_out_valid", 32'(out_valid), 1);
      chk("t2_out_data",  32'(out_data),  12);
      chk("t2_out_sel",   32'(out_sel),   2);
      in_valid = '0;
      tick();

      // Continuous demand: one grant per cycle in rotation
      do_reset();
      in_valid = '1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("t3_grant", 32'(last_win), 32'(fx(k % N)));
         chk("t3_data",  32'(out_data), 32'(10 + fx(k % N)));
      end

      // Backpressure holds output and blocks grants
      do_reset();
      in_valid = '1;
      tick();
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_nogrant", 32'(last_win), 32'hFFFF_FFFF);
         chk("t4_hold",    32'(out_data), 32'(10 + fx(1)));
      end
      out_ready = 1'b1;
      tick();
      chk("t4_next", 32'(last_win), 32'(fx(2)));

      // Wrap from last_grant=4 with sparse requests
      do_reset();
      in_valid = 5'b01010;
      tick(); chk("t5_g0", 32'(last_win), 1);
      tick(); chk("t5_g1", 32'(last_win), 32'(fx(3) == 0 ? 1 : 3));
      tick(); chk("t5_g2", 32'(last_win), 1);

      // Reset while holding a transfer
      do_reset();
      in_valid = '1;
      for (int k = 0; k < 4; k++) tick();
      chk("t6_pre_sel", 32'(out_sel), 32'(fx(3)));
      do_reset();
      chk("t6_cleared", 32'(out_valid), 0);
      tick();
      chk("t6_first", 32'(last_win), 0);

      // Randomized traffic with random backpressure and rare resets
      for (int k = 0; k < 400; k++) begin
         in_valid  = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < N; i++) in_bus[i] = W'($urandom);
         tick();
      end
      rst = 1'b0;
      in_valid = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
